// File: rtl/dmem_access_ctrl.sv
// Sequences word-wide data memory accesses for the CPU load/store port and the loader port.
// Latency grant->ack: load 3, SW/loader write 2, SB/SH 4, error 1; DONE always returns to IDLE.
// Backpressure: requesters hold req and payload stable until their one-cycle ack.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   cpu_req/op/addr/wdata        CPU access request (LW,LB,LBU,LH,LHU,SW,SB,SH)
//   cpu_ack/rdata/err            CPU completion pulse, load data, error flag
//   ldr_req/we/addr/wdata        loader word read/write request
//   ldr_ack/rdata/err            loader completion pulse, read word, error flag
//   mem_rena/wena/addr/wdata     RAM control (word index), mem_rdata valid 1 cycle after rena
module dmem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          DEPTH     = 800,
    parameter int          AW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [2:0]    cpu_op,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [31:0]   ldr_addr,
    input  logic [31:0]   ldr_wdata,
    output logic          ldr_ack,
    output logic [31:0]   ldr_rdata,
    output logic          ldr_err,
    output logic          mem_rena,
    output logic          mem_wena,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    state_t        state_q, state_d;
    logic          last_ldr_q, last_ldr_d;   // 1 = loader was granted last
    logic          sel_ldr_q, sel_ldr_d;     // owner of the access in flight
    logic [2:0]    op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mem_rena_q, mem_rena_d;
    logic          mem_wena_q, mem_wena_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic          cpu_err_q, cpu_err_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic [31:0]   ldr_rdata_q, ldr_rdata_d;
    logic          ldr_err_q, ldr_err_d;

    // Grant decode for the IDLE cycle. The loader only wins a tie if the CPU went last.
    logic          g_vld, g_ldr, g_err, g_misal;
    logic [2:0]    g_op;
    logic [31:0]   g_addr, g_wdata, g_off;

    assign g_vld   = cpu_req | ldr_req;
    assign g_ldr   = ldr_req & (~cpu_req | ~last_ldr_q);
    assign g_op    = g_ldr ? (ldr_we ? OP_SW : OP_LW) : cpu_op;
    assign g_addr  = g_ldr ? ldr_addr : cpu_addr;
    assign g_wdata = g_ldr ? ldr_wdata : cpu_wdata;
    // Wrapping subtract: addresses below the base become huge offsets and fail the range test.
    assign g_off   = g_addr - BASE_ADDR;
    assign g_err   = (g_off >= SPAN) | g_misal;

    always_comb begin
        g_misal = 1'b0;
        case (g_op)
            OP_LW, OP_SW:          g_misal = (g_off[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  g_misal = g_off[0];
            default:               g_misal = 1'b0;
        endcase
    end

    // Lane extraction and lane merge from the word captured in CAP.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val, merged;

    always_comb begin
        rd_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
        rd_half  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        load_val = mem_rdata;
        case (op_q)
            OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_val = {24'h0, rd_byte};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {16'h0, rd_half};
            default: load_val = mem_rdata;
        endcase
        merged = mem_rdata;
        if (op_q == OP_SB) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    logic        done_ack, done_err, done_ldr;
    logic [31:0] done_rdata;

    always_comb begin
        state_d     = state_q;
        last_ldr_d  = last_ldr_q;
        sel_ldr_d   = sel_ldr_q;
        op_d        = op_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mem_rena_d  = 1'b0;
        mem_wena_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_ack    = 1'b0;
        done_err    = 1'b0;
        done_ldr    = sel_ldr_q;
        done_rdata  = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (g_vld) begin
                    last_ldr_d = g_ldr;
                    sel_ldr_d  = g_ldr;
                    op_d       = g_op;
                    lane_d     = g_off[1:0];
                    wdata_d    = g_wdata;
                    if (g_err) begin
                        // Ack straight away; owner comes from the live grant, not sel_ldr_q.
                        done_ack = 1'b1;
                        done_err = 1'b1;
                        done_ldr = g_ldr;
                        state_d  = S_DONE;
                    end else begin
                        mem_addr_d = g_off[AW+1:2];
                        if (g_op == OP_SW) begin
                            mem_wena_d  = 1'b1;
                            mem_wdata_d = g_wdata;
                            state_d     = S_WR;
                        end else begin
                            mem_rena_d = 1'b1;
                            state_d    = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (op_q == OP_SB || op_q == OP_SH) begin
                    mem_wena_d  = 1'b1;
                    mem_wdata_d = merged;
                    state_d     = S_WR;
                end else begin
                    done_ack   = 1'b1;
                    done_rdata = load_val;
                    state_d    = S_DONE;
                end
            end
            S_WR: begin
                done_ack = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cpu_ack_d   = done_ack & ~done_ldr;
        cpu_err_d   = done_err & ~done_ldr;
        cpu_rdata_d = done_ldr ? 32'h0 : done_rdata;
        ldr_ack_d   = done_ack & done_ldr;
        ldr_err_d   = done_err & done_ldr;
        ldr_rdata_d = done_ldr ? done_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_ldr_q  <= 1'b1;
            sel_ldr_q   <= 1'b0;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            wdata_q     <= 32'h0;
            mem_rena_q  <= 1'b0;
            mem_wena_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= 32'h0;
            cpu_err_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            ldr_rdata_q <= 32'h0;
            ldr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ldr_q  <= last_ldr_d;
            sel_ldr_q   <= sel_ldr_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mem_rena_q  <= mem_rena_d;
            mem_wena_q  <= mem_wena_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
            ldr_ack_q   <= ldr_ack_d;
            ldr_rdata_q <= ldr_rdata_d;
            ldr_err_q   <= ldr_err_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;
    assign ldr_ack   = ldr_ack_q;
    assign ldr_rdata = ldr_rdata_q;
    assign ldr_err   = ldr_err_q;
    assign mem_rena  = mem_rena_q;
    assign mem_wena  = mem_wena_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [2:0]  cpu_op = 3'b000;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_ack, cpu_err;
    logic [31:0] cpu_rdata;
    logic        ldr_req = 1'b0;
    logic        ldr_we = 1'b0;
    logic [31:0] ldr_addr = 32'h0;
    logic [31:0] ldr_wdata = 32'h0;
    logic        ldr_ack, ldr_err;
    logic [31:0] ldr_rdata;
    logic        mem_rena, mem_wena;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_err(ldr_err),
        .mem_rena(mem_rena), .mem_wena(mem_wena), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM environment: read data appears the cycle after rena.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_wena) ram[mem_addr] <= mem_wdata;
        if (mem_rena) mem_rdata <= ram[mem_addr];
    end

    // Monitor (sampled mid-cycle): running totals only, diffed by the tests.
    int cyc = 0, rena_total = 0, wena_total = 0, ack_total = 0;
    int both_en_total = 0, dual_ack_total = 0, last_rena_cyc = 0, last_wena_cyc = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_rena) begin rena_total <= rena_total + 1; last_rena_cyc <= cyc; end
        if (mem_wena) begin wena_total <= wena_total + 1; last_wena_cyc <= cyc; end
        if (mem_rena && mem_wena) both_en_total <= both_en_total + 1;
        if (cpu_ack || ldr_ack) ack_total <= ack_total + 1;
        if (cpu_ack && ldr_ack) dual_ack_total <= dual_ack_total + 1;
    end

    logic [111:0] outs;
    assign outs = {cpu_ack, cpu_err, cpu_rdata, ldr_ack, ldr_err, ldr_rdata,
                   mem_rena, mem_wena, mem_addr, mem_wdata};

    typedef struct {
        logic        ldr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3,
                           LHU = 3'd4, SW = 3'd5, SB = 3'd6, SH = 3'd7;

    // Drivers: called in an IDLE cycle, return observations, end in the next IDLE cycle.
    task automatic cpu_xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat,
                            output int nr, output int nw);
        int r0, w0;
        r0 = rena_total; w0 = wena_total; lat = -1;
        cpu_op = op; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin lat = i; break; end
        end
        rd = cpu_rdata; er = cpu_err; cpu_req = 1'b0;
        @(posedge clk); #1;
        nr = rena_total - r0; nw = wena_total - w0;
    endtask

    task automatic ldr_xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat,
                            output int nr, output int nw);
        int r0, w0;
        r0 = rena_total; w0 = wena_total; lat = -1;
        ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ldr_ack) begin lat = i; break; end
        end
        rd = ldr_rdata; er = ldr_err; ldr_req = 1'b0;
        @(posedge clk); #1;
        nr = rena_total - r0; nw = wena_total - w0;
    endtask

    task automatic apply_reset();
        cpu_req = 1'b0; ldr_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; #3;
        checks++;
        if (outs !== 112'h0) begin errors++; $display("FAIL reset_in: outs=%h want 0", outs); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (outs !== 112'h0) begin errors++; $display("FAIL reset_idle: outs=%h want 0", outs); end
    endtask

    task automatic test_write_lb();
        logic [31:0] rd; logic er; int lat, nr, nw; exp_t e;
        sb_q.push_back('{1'b1, 32'h0, 1'b0, 2});
        ldr_xact(1'b1, 32'h1001_0004, 32'hA1B2_C3D4, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat || nr != 0 || nw != 1) begin
            errors++;
            $display("FAIL ldr_write: rd=%h err=%b lat=%0d nr=%0d nw=%0d want rd=%h err=%b lat=%0d nr=0 nw=1",
                     rd, er, lat, nr, nw, e.rdata, e.err, e.lat);
        end
        sb_q.push_back('{1'b0, 32'hFFFF_FFA1, 1'b0, 3});
        cpu_xact(LB, 32'h1001_0007, 32'h0, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat || nr != 1 || nw != 0) begin
            errors++;
            $display("FAIL cpu_lb: rd=%h err=%b lat=%0d nr=%0d nw=%0d want rd=%h err=%b lat=%0d",
                     rd, er, lat, nr, nw, e.rdata, e.err, e.lat);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [6] = '{LBU, LH, LHU, LW, LB, LBU};
        logic [31:0] adrs [6] = '{32'h1001_0006, 32'h1001_0004, 32'h1001_0006,
                                  32'h1001_0004, 32'h1001_0004, 32'h1001_0005};
        logic [31:0] exps [6] = '{32'h0000_00B2, 32'hFFFF_C3D4, 32'h0000_A1B2,
                                  32'hA1B2_C3D4, 32'hFFFF_FFD4, 32'h0000_00C3};
        logic [31:0] rd; logic er; int lat, nr, nw; exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{1'b0, exps[i], 1'b0, 3});
            cpu_xact(ops[i], adrs[i], 32'hFFFF_FFFF, rd, er, lat, nr, nw);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
                errors++;
                $display("FAIL load_%0d: rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_rmw();
        logic [31:0] rd; logic er; int lat, nr, nw; exp_t e;
        sb_q.push_back('{1'b0, 32'h0, 1'b0, 4});
        cpu_xact(SB, 32'h1001_0005, 32'hDEAD_BE55, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat || nr != 1 || nw != 1 ||
            last_rena_cyc >= last_wena_cyc) begin
            errors++;
            $display("FAIL sb_rmw: rd=%h err=%b lat=%0d nr=%0d nw=%0d rcyc=%0d wcyc=%0d want lat=4 nr=1 nw=1 read first",
                     rd, er, lat, nr, nw, last_rena_cyc, last_wena_cyc);
        end
        sb_q.push_back('{1'b0, 32'hA1B2_55D4, 1'b0, 3});
        cpu_xact(LW, 32'h1001_0004, 32'h0, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || lat != e.lat) begin
            errors++; $display("FAIL sb_readback: rd=%h lat=%0d want %h lat=%0d", rd, lat, e.rdata, e.lat);
        end
        sb_q.push_back('{1'b0, 32'h0, 1'b0, 4});
        cpu_xact(SH, 32'h1001_0006, 32'hFFFF_1234, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat || nw != 1) begin
            errors++; $display("FAIL sh_rmw: rd=%h err=%b lat=%0d nw=%0d want lat=4 nw=1", rd, er, lat, nw);
        end
        sb_q.push_back('{1'b1, 32'h1234_55D4, 1'b0, 3});
        ldr_xact(1'b0, 32'h1001_0004, 32'h0, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            errors++; $display("FAIL sh_readback: rd=%h err=%b lat=%0d want %h lat=%0d", rd, er, lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ops  [6] = '{LH, LW, LW, SW, LW, LHU};
        logic [31:0] adrs [6] = '{32'h1001_0001, 32'h1001_0C80, 32'h1000_FFFC,
                                  32'h1001_0C80, 32'h1001_0002, 32'h1001_0003};
        logic [31:0] rd; logic er; int lat, nr, nw; exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{1'b0, 32'h0, 1'b1, 1});
            cpu_xact(ops[i], adrs[i], 32'h1234_5678, rd, er, lat, nr, nw);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err || lat != e.lat || nr != 0 || nw != 0) begin
                errors++;
                $display("FAIL err_%0d: rd=%h err=%b lat=%0d nr=%0d nw=%0d want rd=0 err=1 lat=1 no mem",
                         i, rd, er, lat, nr, nw);
            end
        end
        sb_q.push_back('{1'b1, 32'h0, 1'b1, 1});
        ldr_xact(1'b0, 32'h1001_0002, 32'h0, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat || nr != 0) begin
            errors++; $display("FAIL ldr_misaligned: rd=%h err=%b lat=%0d nr=%0d want err=1 lat=1", rd, er, lat, nr);
        end
        // Last valid word sits just below the range limit.
        ldr_xact(1'b1, 32'h1001_0C7C, 32'hCAFE_F00D, rd, er, lat, nr, nw);
        sb_q.push_back('{1'b0, 32'hCAFE_F00D, 1'b0, 3});
        cpu_xact(LW, 32'h1001_0C7C, 32'h0, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            errors++; $display("FAIL last_word: rd=%h err=%b lat=%0d want %h err=0 lat=3", rd, er, lat, e.rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, nr, nw, nack, d0, b0; exp_t e;
        logic [31:0] got;
        ldr_xact(1'b1, 32'h1001_0010, 32'h1111_2222, rd, er, lat, nr, nw);
        ldr_xact(1'b1, 32'h1001_0014, 32'h3333_4444, rd, er, lat, nr, nw);
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{1'b0, 32'h1111_2222, 1'b0, 0});
            sb_q.push_back('{1'b1, 32'h3333_4444, 1'b0, 0});
        end
        d0 = dual_ack_total; b0 = both_en_total; nack = 0;
        cpu_op = LW; cpu_addr = 32'h1001_0010; cpu_req = 1'b1;
        ldr_we = 1'b0; ldr_addr = 32'h1001_0014; ldr_req = 1'b1;
        for (int i = 0; i < 60 && nack < 4; i++) begin
            @(posedge clk); #1;
            if (cpu_ack || ldr_ack) begin
                e = sb_q.pop_front();
                got = ldr_ack ? ldr_rdata : cpu_rdata;
                checks++;
                if (ldr_ack !== e.ldr || got !== e.rdata) begin
                    errors++;
                    $display("FAIL grant_%0d: ldr_ack=%b data=%h want ldr_ack=%b data=%h",
                             nack, ldr_ack, got, e.ldr, e.rdata);
                end
                nack++;
                if (nack == 4) begin cpu_req = 1'b0; ldr_req = 1'b0; end
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (nack != 4 || dual_ack_total != d0 || both_en_total != b0) begin
            errors++;
            $display("FAIL b2b_summary: acks=%0d dual=%0d both_en=%0d want acks=4 dual=0 both_en=0",
                     nack, dual_ack_total - d0, both_en_total - b0);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic er; int lat, nr, nw, w0, a0; exp_t e;
        w0 = wena_total; a0 = ack_total;
        cpu_op = SH; cpu_addr = 32'h1001_0006; cpu_wdata = 32'h0000_BEEF; cpu_req = 1'b1;
        @(posedge clk); #1;   // RD
        @(posedge clk); #1;   // CAP
        rst = 1'b1; #1;
        checks++;
        if (outs !== 112'h0) begin errors++; $display("FAIL rst_mid_outs: outs=%h want 0", outs); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (wena_total != w0 || ack_total != a0) begin
            errors++; $display("FAIL rst_mid_effects: wena=%0d ack=%0d want 0 0", wena_total - w0, ack_total - a0);
        end
        sb_q.push_back('{1'b0, 32'h1234_55D4, 1'b0, 3});
        cpu_xact(LW, 32'h1001_0004, 32'h0, rd, er, lat, nr, nw);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            errors++; $display("FAIL rst_mid_after: rd=%h err=%b lat=%0d want %h err=0 lat=3", rd, er, lat, e.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_lb();
        test_loads();
        test_rmw();
        test_errors();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (both_en_total != 0) begin
            errors++; $display("FAIL rena_wena_overlap: count=%0d want 0", both_en_total);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
